sr_latch: RTL and testbench



---
 rtl/sr_latch.sv | 64 ++++++
 tb/tb_sr_latch.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sr_latch.sv
// Clocked, enable-gated SR storage cell with complementary outputs and a forbidden-input flag.
// Build option SR_LATCH_SET_PRIORITY_EN: treat s=r=1 as set instead of the NOR-latch 0/0 result.
module sr_latch (
  input  logic clk,
  input  logic rst_n,
  input  logic e,
  input  logic s,
  input  logic r,
  output logic q,
  output logic q_bar,
  output logic invalid
);

  logic q_q, q_d;
  logic q_bar_q, q_bar_d;
  logic invalid_q, invalid_d;

  always_comb begin
    q_d       = q_q;
    q_bar_d   = q_bar_q;
    invalid_d = 1'b0;
    if (e) begin
      unique case ({s, r})
        2'b01: begin
          q_d     = 1'b0;
          q_bar_d = 1'b1;
        end
        2'b10: begin
          q_d     = 1'b1;
          q_bar_d = 1'b0;
        end
        2'b11: begin
          invalid_d = 1'b1;
`ifdef SR_LATCH_SET_PRIORITY_EN
          q_d     = 1'b1;
          q_bar_d = 1'b0;
`else
          // Both NOR outputs are driven low; holds keep this 0/0 pair.
          q_d     = 1'b0;
          q_bar_d = 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q       <= 1'b0;
      q_bar_q   <= 1'b1;
      invalid_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      q_bar_q   <= q_bar_d;
      invalid_q <= invalid_d;
    end
  end

  assign q       = q_q;
  assign q_bar   = q_bar_q;
  assign invalid = invalid_q;

endmodule

// File: tb/tb_sr_latch.sv
// Directed self-checking bench for sr_latch; expectations follow SR_LATCH_SET_PRIORITY_EN if defined.
module tb_sr_latch;

  logic clk = 1'b0;
  logic rst_n, e, s, r;
  logic q, q_bar, invalid;

  int errors = 0;
  int checks = 0;

`ifdef SR_LATCH_SET_PRIORITY_EN
  localparam logic [2:0] FORB = 3'b101;
`else
  localparam logic [2:0] FORB = 3'b001;
`endif
  localparam logic [2:0] RST_V = 3'b010;
  localparam logic [2:0] SET_V = 3'b100;

  sr_latch dut (
    .clk(clk), .rst_n(rst_n), .e(e), .s(s), .r(r),
    .q(q), .q_bar(q_bar), .invalid(invalid)
  );

  always #5 clk = ~clk;

  // Drive {e,s,r}, take one rising edge, then settle 1ns past it before sampling.
  task automatic cycle(input logic [2:0] esr);
    {e, s, r} = esr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [2:0] got;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cycle(3'b110);
      got = {q, q_bar, invalid};
      checks++;
      if (got !== RST_V) begin
        errors++;
        $display("FAIL reset_hold[%0d] got=%b exp=%b", i, got, RST_V);
      end
    end
    rst_n = 1'b1;
    cycle(3'b000);
    got = {q, q_bar, invalid};
    checks++;
    if (got !== RST_V) begin
      errors++;
      $display("FAIL reset_release got=%b exp=%b", got, RST_V);
    end
  endtask

  task automatic test_sweep();
    logic [2:0] exp_tab [8];
    logic [2:0] got;
    logic [2:0] v;
    exp_tab = '{RST_V, RST_V, RST_V, RST_V, RST_V, RST_V, SET_V, FORB};
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      cycle(v);
      got = {q, q_bar, invalid};
      checks++;
      if (got !== exp_tab[i]) begin
        errors++;
        $display("FAIL sweep esr=%b got=%b exp=%b", v, got, exp_tab[i]);
      end
    end
  endtask

  task automatic test_enable_gating();
    logic [2:0] got;
    cycle(3'b110);
    got = {q, q_bar, invalid};
    checks++;
    if (got !== SET_V) begin
      errors++;
      $display("FAIL gate_set got=%b exp=%b", got, SET_V);
    end
    for (int i = 0; i < 6; i++) begin
      cycle(i < 3 ? 3'b001 : 3'b010);
      got = {q, q_bar, invalid};
      checks++;
      if (got !== SET_V) begin
        errors++;
        $display("FAIL gate_hold[%0d] got=%b exp=%b", i, got, SET_V);
      end
    end
  endtask

  task automatic test_forbidden_hold();
    logic [2:0] got;
    logic [2:0] held;
    cycle(3'b101);
    cycle(3'b111);
    got = {q, q_bar, invalid};
    checks++;
    if (got !== FORB) begin
      errors++;
      $display("FAIL forbid got=%b exp=%b", got, FORB);
    end
    held = {FORB[2:1], 1'b0};
    for (int i = 0; i < 2; i++) begin
      cycle(3'b100);
      got = {q, q_bar, invalid};
      checks++;
      if (got !== held) begin
        errors++;
        $display("FAIL forbid_hold[%0d] got=%b exp=%b", i, got, held);
      end
    end
    // Disabled inputs must also keep the pair left by the forbidden cycle.
    cycle(3'b011);
    got = {q, q_bar, invalid};
    checks++;
    if (got !== held) begin
      errors++;
      $display("FAIL forbid_hold_dis got=%b exp=%b", got, held);
    end
    cycle(3'b110);
    got = {q, q_bar, invalid};
    checks++;
    if (got !== SET_V) begin
      errors++;
      $display("FAIL forbid_recover got=%b exp=%b", got, SET_V);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] got;
    cycle(3'b101);
    for (int i = 0; i < 3; i++) begin
      cycle(3'b111);
      got = {q, q_bar, invalid};
      checks++;
      if (got !== FORB) begin
        errors++;
        $display("FAIL b2b_forbid[%0d] got=%b exp=%b", i, got, FORB);
      end
    end
    cycle(3'b101);
    got = {q, q_bar, invalid};
    checks++;
    if (got !== RST_V) begin
      errors++;
      $display("FAIL b2b_restore got=%b exp=%b", got, RST_V);
    end
  endtask

  task automatic test_registered_outputs();
    logic [2:0] got;
    cycle(3'b110);
    {e, s, r} = 3'b101;
    #2;
    got = {q, q_bar, invalid};
    checks++;
    if (got !== SET_V) begin
      errors++;
      $display("FAIL no_comb_path got=%b exp=%b", got, SET_V);
    end
  endtask

  task automatic test_reset_collision();
    logic [2:0] got;
    cycle(3'b110);
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cycle(3'b111);
      got = {q, q_bar, invalid};
      checks++;
      if (got !== RST_V) begin
        errors++;
        $display("FAIL rst_collision[%0d] got=%b exp=%b", i, got, RST_V);
      end
    end
    rst_n = 1'b1;
    cycle(3'b100);
    got = {q, q_bar, invalid};
    checks++;
    if (got !== RST_V) begin
      errors++;
      $display("FAIL rst_collision_release got=%b exp=%b", got, RST_V);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    {e, s, r} = 3'b000;
    test_reset();
    test_sweep();
    test_enable_gating();
    test_forbidden_hold();
    test_back_to_back();
    test_registered_outputs();
    test_reset_collision();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
